// File: rtl/ledscan_hub75_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ledscan_hub75_driver_pkg
// Purpose  : Shared panel geometry, scan FSM state encoding and a counter
//            width helper for the HUB75 scan driver and its shifter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ledscan_hub75_driver_pkg;

  localparam int PANEL_COLS = 64;
  localparam int PANEL_ROWS = 64;
  localparam int SCAN_ROWS  = 32;

  // Panel row-pair select and frame-store row address widths.
  localparam int ROW_W     = $clog2(SCAN_ROWS);
  localparam int ADDR_W    = $clog2(PANEL_ROWS);
  // Holds 0..PANEL_COLS inclusive.
  localparam int BIT_CNT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_U = 3'd1,
    ST_FETCH_L = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_BLANK   = 3'd4,
    ST_LATCH   = 3'd5,
    ST_DISPLAY = 3'd6
  } state_t;

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : ledscan_hub75_driver_pkg
`default_nettype wire

// File: rtl/ledscan_hub75_driver_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ledscan_hub75_driver_shifter
// Purpose  : Dual 64-bit row shift registers (upper/lower half of the panel)
//            with a CLK_DIV divider generating hub_clk. Column 63 leaves
//            first; data changes only on the falling hub_clk edge.
// Ports    : clk, rst_n        - system clock, async active-low reset
//            load_u / load_l   - capture row_data into the upper/lower reg
//            start             - begin a 64-bit shift burst
//            row_data [63:0]   - frame-store row data
//            busy              - high for every shift cycle except the last
//            hub_clk/r1/r2     - panel shift clock and pixel data
// Revision : 1.0 - initial release
// ============================================================================
module ledscan_hub75_driver_shifter
  import ledscan_hub75_driver_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_u,
  input  logic                  load_l,
  input  logic                  start,
  input  logic [PANEL_COLS-1:0] row_data,
  output logic                  busy,
  output logic                  hub_clk,
  output logic                  hub_r1,
  output logic                  hub_r2
);

  localparam int c_div_w = cnt_width(CLK_DIV);

  logic [PANEL_COLS-1:0] r_shreg_u;
  logic [PANEL_COLS-1:0] r_shreg_l;
  logic [c_div_w-1:0]    r_div_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_active;
  logic                  r_hub_clk;
  logic                  w_div_end;
  logic                  w_last_bit;

  assign w_div_end  = (r_div_cnt == c_div_w'(CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(PANEL_COLS - 1));

  // busy drops during the final high half-period of bit 63 so the scan FSM
  // leaves SHIFT on the same edge the burst ends, adding no idle cycle.
  assign busy    = r_active & ~(r_hub_clk & w_div_end & w_last_bit);
  assign hub_clk = r_hub_clk;
  // Gated so the panel sees 0 outside a burst even while a row is loaded.
  assign hub_r1  = r_active & r_shreg_u[PANEL_COLS-1];
  assign hub_r2  = r_active & r_shreg_l[PANEL_COLS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg_u <= '0;
      r_shreg_l <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_active  <= 1'b0;
      r_hub_clk <= 1'b0;
    end else begin
      if (load_u) r_shreg_u <= row_data;
      if (load_l) r_shreg_l <= row_data;

      if (start) begin
        r_active  <= 1'b1;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_hub_clk <= 1'b0;
      end else if (r_active) begin
        if (w_div_end) begin
          r_div_cnt <= '0;
          if (!r_hub_clk) begin
            r_hub_clk <= 1'b1;
          end else begin
            // Falling edge: advance to the next column (zero fill, so the
            // registers are empty once all 64 columns have left).
            r_hub_clk <= 1'b0;
            r_shreg_u <= {r_shreg_u[PANEL_COLS-2:0], 1'b0};
            r_shreg_l <= {r_shreg_l[PANEL_COLS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit) r_active <= 1'b0;
          end
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

endmodule : ledscan_hub75_driver_shifter
`default_nettype wire

// File: rtl/ledscan_hub75_driver.sv
`default_nettype none
// ============================================================================
// Module   : ledscan_hub75_driver
// Purpose  : Scans a 64x64 1-bit frame store and drives a HUB75 1/32-scan
//            panel: fetch rows r and r+32, shift 64 columns, blank, latch,
//            display, next row pair.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            en                  - scan enable (sampled in IDLE / end of row)
//            fb_row_addr [5:0]   - frame row being read
//            fb_row_data [63:0]  - row data, valid 1 cycle after address
//            hub_clk/r1/r2       - panel shift clock and pixel data
//            hub_addr [4:0]      - panel row-pair select
//            hub_lat             - latch strobe (active high)
//            hub_oe_n            - output enable (active low)
//            frame_start         - pulse on first fetch of row pair 0
//            brightness [7:0]    - PWM duty, only with LEDSCAN_DIM_EN
// Config   : LEDSCAN_DIM_EN - adds brightness port and PWM gating of
//            hub_oe_n during DISPLAY; scan timing is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module ledscan_hub75_driver
  import ledscan_hub75_driver_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int BLANK_CYCLES   = 2,
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [ADDR_W-1:0]     fb_row_addr,
  input  logic [PANEL_COLS-1:0] fb_row_data,
  output logic                  hub_clk,
  output logic                  hub_r1,
  output logic                  hub_r2,
  output logic [ROW_W-1:0]      hub_addr,
  output logic                  hub_lat,
  output logic                  hub_oe_n,
  output logic                  frame_start
`ifdef LEDSCAN_DIM_EN
  ,
  input  logic [7:0]            brightness
`endif
);

  // Step counter covers the 2-cycle fetches and the blank interval.
  localparam int c_step_w = cnt_width((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  // At least 8 bits so the PWM compare has a full 256-cycle window.
  localparam int c_disp_w = (cnt_width(DISPLAY_CYCLES) > 8) ?
                            cnt_width(DISPLAY_CYCLES) : 8;

  state_t                r_state;
  state_t                w_next_state;
  logic [c_step_w-1:0]   r_step_cnt;
  logic [c_disp_w-1:0]   r_disp_cnt;
  logic [ROW_W-1:0]      r_row;
  logic [ROW_W-1:0]      r_hub_addr;
  logic                  r_frame_start;

  logic w_fetch_done;
  logic w_blank_done;
  logic w_disp_done;
  logic w_state_change;
  logic w_frame_start_next;
  logic w_shift_busy;
  logic w_load_u;
  logic w_load_l;
  logic w_start;

  assign w_fetch_done   = (r_step_cnt == c_step_w'(1));
  assign w_blank_done   = (r_step_cnt == c_step_w'(BLANK_CYCLES - 1));
  assign w_disp_done    = (r_disp_cnt == c_disp_w'(DISPLAY_CYCLES - 1));
  assign w_state_change = (w_next_state != r_state);

  // A new frame begins either from IDLE or when row 31 wraps back to 0.
  assign w_frame_start_next =
      ((r_state == ST_IDLE) && en) ||
      ((r_state == ST_DISPLAY) && w_disp_done && en &&
       (r_row == ROW_W'(SCAN_ROWS - 1)));

  assign hub_addr    = r_hub_addr;
  assign frame_start = r_frame_start;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (en)            w_next_state = ST_FETCH_U;
      ST_FETCH_U: if (w_fetch_done)  w_next_state = ST_FETCH_L;
      ST_FETCH_L: if (w_fetch_done)  w_next_state = ST_SHIFT;
      ST_SHIFT:   if (!w_shift_busy) w_next_state = ST_BLANK;
      ST_BLANK:   if (w_blank_done)  w_next_state = ST_LATCH;
      ST_LATCH:                      w_next_state = ST_DISPLAY;
      ST_DISPLAY: if (w_disp_done)   w_next_state = en ? ST_FETCH_U : ST_IDLE;
      default:                       w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from state. hub_oe_n and hub_lat follow r_state directly,
  // so an asynchronous reset blanks the panel without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    hub_oe_n    = 1'b1;
    hub_lat     = 1'b0;
    fb_row_addr = '0;
    w_load_u    = 1'b0;
    w_load_l    = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      ST_FETCH_U: begin
        fb_row_addr = {1'b0, r_row};
        w_load_u    = w_fetch_done;
      end
      ST_FETCH_L: begin
        // Lower half row is r + 32: the MSB of the 6-bit address.
        fb_row_addr = {1'b1, r_row};
        w_load_l    = w_fetch_done;
        w_start     = w_fetch_done;
      end
      ST_LATCH: hub_lat = 1'b1;
      ST_DISPLAY: begin
`ifdef LEDSCAN_DIM_EN
        hub_oe_n = ~(r_disp_cnt[7:0] < brightness);
`else
        hub_oe_n = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Step/display counters, row counter, panel address, frame pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt    <= '0;
      r_disp_cnt    <= '0;
      r_row         <= '0;
      r_hub_addr    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      if (((r_state == ST_FETCH_U) || (r_state == ST_FETCH_L) ||
           (r_state == ST_BLANK)) && !w_state_change)
        r_step_cnt <= r_step_cnt + 1'b1;
      else
        r_step_cnt <= '0;

      if ((r_state == ST_DISPLAY) && !w_disp_done)
        r_disp_cnt <= r_disp_cnt + 1'b1;
      else
        r_disp_cnt <= '0;

      if ((r_state == ST_IDLE) && en)
        r_row <= '0;
      else if ((r_state == ST_DISPLAY) && w_disp_done)
        r_row <= r_row + 1'b1;

      // Panel address only changes while the outputs are blanked.
      if ((r_state == ST_BLANK) && (r_step_cnt == '0))
        r_hub_addr <= r_row;

      r_frame_start <= w_frame_start_next;
    end
  end

  ledscan_hub75_driver_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_u   (w_load_u),
    .load_l   (w_load_l),
    .start    (w_start),
    .row_data (fb_row_data),
    .busy     (w_shift_busy),
    .hub_clk  (hub_clk),
    .hub_r1   (hub_r1),
    .hub_r2   (hub_r2)
  );

endmodule : ledscan_hub75_driver
`default_nettype wire

// File: tb/tb_ledscan_hub75_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ledscan_hub75_driver
// Purpose  : Directed self-checking bench for ledscan_hub75_driver with a
//            registered-read frame store model. Sample index s counts
//            negedges after reset release; a row pair takes 519 samples.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ledscan_hub75_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  fb_row_addr;
  logic [63:0] fb_row_data = '0;
  logic        hub_clk;
  logic        hub_r1;
  logic        hub_r2;
  logic [4:0]  hub_addr;
  logic        hub_lat;
  logic        hub_oe_n;
  logic        frame_start;
`ifdef LEDSCAN_DIM_EN
  logic [7:0]  brightness;
  localparam int EXP_ON = 64;
`else
  localparam int EXP_ON = 256;
`endif

  logic [63:0] mem [0:63];
  int          tests  = 0;
  int          failed = 0;

  int          rises, lat_cnt, oe_lo, fs_cnt, n_lat, fs_at, nz_addr;
  logic [63:0] v1, v2;
  logic        prev_clk;
  logic [4:0]  exp_addr;

  always #5 clk = ~clk;

  // Frame store: data for an address appears one clock later.
  always @(posedge clk) fb_row_data <= mem[fb_row_addr];

  ledscan_hub75_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fb_row_addr (fb_row_addr),
    .fb_row_data (fb_row_data),
    .hub_clk     (hub_clk),
    .hub_r1      (hub_r1),
    .hub_r2      (hub_r2),
    .hub_addr    (hub_addr),
    .hub_lat     (hub_lat),
    .hub_oe_n    (hub_oe_n),
    .frame_start (frame_start)
`ifdef LEDSCAN_DIM_EN
    ,
    .brightness  (brightness)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rises = 0; lat_cnt = 0; oe_lo = 0; fs_cnt = 0;
    v1 = '0; v2 = '0; prev_clk = hub_clk;
  endtask

  // Collect pixel data at each hub_clk rise plus strobe/enable counts.
  task automatic observe();
    if (hub_clk && !prev_clk) begin
      rises++;
      v1 = {v1[62:0], hub_r1};
      v2 = {v2[62:0], hub_r2};
    end
    prev_clk = hub_clk;
    if (hub_lat)     lat_cnt++;
    if (!hub_oe_n)   oe_lo++;
    if (frame_start) fs_cnt++;
  endtask

  initial begin
    for (int r = 0; r < 64; r++) mem[r] = '0;
    mem[0]  = 64'h8000_0000_0000_0001;
    mem[32] = 64'h0000_0000_0000_0001;
    mem[5]  = 64'hA5A5_0000_FFFF_1234;
    mem[37] = 64'h0F0F_F0F0_0000_8001;
    rst_n = 1'b0;
    en    = 1'b1;
`ifdef LEDSCAN_DIM_EN
    brightness = 8'd64;
`endif
    repeat (3) @(negedge clk);

    // Reset values while rst_n is held low with en=1.
    chk("rst_oe_n",        {63'd0, hub_oe_n},    64'd1);
    chk("rst_hub_clk",     {63'd0, hub_clk},     64'd0);
    chk("rst_r1",          {63'd0, hub_r1},      64'd0);
    chk("rst_r2",          {63'd0, hub_r2},      64'd0);
    chk("rst_lat",         {63'd0, hub_lat},     64'd0);
    chk("rst_frame_start", {63'd0, frame_start}, 64'd0);
    chk("rst_hub_addr",    {59'd0, hub_addr},    64'd0);
    chk("rst_fb_addr",     {58'd0, fb_row_addr}, 64'd0);

    // Row pair 0: fetch, shift, blank, latch, display.
    rst_n = 1'b1;
    clear_stats();
    for (int s = 1; s <= 520; s++) begin
      @(negedge clk);
      observe();
      if (s == 1) begin
        chk("fs_cycle1",  {63'd0, frame_start}, 64'd1);
        chk("fetch_u_c1", {58'd0, fb_row_addr}, 64'd0);
      end
      if (s == 2) begin
        chk("fs_cycle2",  {63'd0, frame_start}, 64'd0);
        chk("fetch_u_c2", {58'd0, fb_row_addr}, 64'd0);
      end
      if (s == 3)   chk("fetch_l_c1", {58'd0, fb_row_addr}, 64'd32);
      if (s == 4)   chk("fetch_l_c2", {58'd0, fb_row_addr}, 64'd32);
      if (s == 260) chk("last_high",  {63'd0, hub_clk},     64'd1);
      if (s == 261) begin
        chk("post_shift_clk", {63'd0, hub_clk},  64'd0);
        chk("post_shift_r1",  {63'd0, hub_r1},   64'd0);
        chk("post_shift_r2",  {63'd0, hub_r2},   64'd0);
        chk("blank_oe_n",     {63'd0, hub_oe_n}, 64'd1);
      end
      if (s == 262) chk("pre_latch",   {63'd0, hub_lat},  64'd0);
      if (s == 263) begin
        chk("latch_pulse",  {63'd0, hub_lat},  64'd1);
        chk("latch_addr0",  {59'd0, hub_addr}, 64'd0);
        chk("latch_oe_n",   {63'd0, hub_oe_n}, 64'd1);
      end
      if (s == 264) chk("display_start", {63'd0, hub_oe_n},    64'd0);
      if (s == 520) begin
        chk("display_end_oe", {63'd0, hub_oe_n},    64'd1);
        chk("next_row_fetch", {58'd0, fb_row_addr}, 64'd1);
      end
    end
    chk("row0_rises",    rises,   64'd64);
    chk("row0_r1_bits",  v1,      64'h8000_0000_0000_0001);
    chk("row0_r2_bits",  v2,      64'h0000_0000_0000_0001);
    chk("row0_latches",  lat_cnt, 64'd1);
    chk("row0_oe_low",   oe_lo,   EXP_ON);
    chk("row0_fs_count", fs_cnt,  64'd1);

    // Rest of the frame: addresses 1..31, wrap to 0, next frame pulse.
    exp_addr = 5'd1;
    n_lat    = 0;
    fs_at    = 0;
    for (int s = 521; s <= 16872; s++) begin
      @(negedge clk);
      if (hub_lat) begin
        chk("scan_addr", {59'd0, hub_addr}, {59'd0, exp_addr});
        exp_addr = exp_addr + 5'd1;
        n_lat++;
      end
      if (frame_start && fs_at == 0) fs_at = s;
    end
    chk("frame_latches",  n_lat, 64'd32);
    chk("frame_period",   fs_at, 64'd16609);
    chk("frame2_display", {63'd0, hub_oe_n}, 64'd0);

    // Asynchronous reset in the middle of DISPLAY.
    #2 rst_n = 1'b0;
    #1;
    chk("areset_oe_n",  {63'd0, hub_oe_n},    64'd1);
    chk("areset_lat",   {63'd0, hub_lat},     64'd0);
    chk("areset_fs",    {63'd0, frame_start}, 64'd0);
    chk("areset_faddr", {58'd0, fb_row_addr}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Restart from row 0; drop en during the shift of row 5.
    clear_stats();
    nz_addr = 0;
    for (int s = 1; s <= 3715; s++) begin
      @(negedge clk);
      observe();
      if (s == 1) begin
        chk("restart_fs",   {63'd0, frame_start}, 64'd1);
        chk("restart_row0", {58'd0, fb_row_addr}, 64'd0);
      end
      if (s == 2595) clear_stats();
      if (s == 2596) chk("row5_fetch", {58'd0, fb_row_addr}, 64'd5);
      if (s == 2700) en = 1'b0;
      if (s == 2858) begin
        chk("row5_latch", {63'd0, hub_lat},  64'd1);
        chk("row5_addr",  {59'd0, hub_addr}, 64'd5);
      end
      if (s == 3114) begin
        chk("row5_rises",   rises,   64'd64);
        chk("row5_r1_bits", v1,      64'hA5A5_0000_FFFF_1234);
        chk("row5_r2_bits", v2,      64'h0F0F_F0F0_0000_8001);
        chk("row5_latches", lat_cnt, 64'd1);
        chk("row5_oe_low",  oe_lo,   EXP_ON);
        clear_stats();
      end
      if (s == 3115) chk("idle_oe_n", {63'd0, hub_oe_n}, 64'd1);
      if (s >= 3115 && fb_row_addr != 6'd0) nz_addr++;
    end
    chk("idle_rises",   rises,   64'd0);
    chk("idle_latches", lat_cnt, 64'd0);
    chk("idle_oe_low",  oe_lo,   64'd0);
    chk("idle_fetches", nz_addr, 64'd0);

`ifdef LEDSCAN_DIM_EN
    // Zero brightness keeps the panel dark through a full row pair.
    brightness = 8'd0;
    en         = 1'b1;
    clear_stats();
    for (int s = 1; s <= 600; s++) begin
      @(negedge clk);
      observe();
    end
    chk("dim0_oe_low",  oe_lo,   64'd0);
    chk("dim0_latches", lat_cnt, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_ledscan_hub75_driver
`default_nettype wire
